demux_1_2_5bit_reg: RTL and testbench

DEMUX_1_2_5BIT_REG -- requirements
Module: demux_1_2_5bit_reg

---
 rtl/demux_1_2_5bit_reg.sv | 60 ++++++
 tb/tb_demux_1_2_5bit_reg.sv | 102 ++++++++++
 2 files changed

// File: rtl/demux_1_2_5bit_reg.sv
// demux_1_2_5bit_reg: 1-to-2 demultiplexer with one valid/ready holding register per output channel
// Ports: Clk, Reset (sync, active-high); In/Sel/InValid/InReady input handshake;
//        OutA/OutAValid/OutAReady and OutB/OutBValid/OutBReady output channels.
// Optional: define DEMUX_CNT_EN to add the 8-bit CountA/CountB delivered-word counters.
module demux_1_2_5bit_reg #(
  parameter int WIDTH = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Sel,
  input  logic [WIDTH-1:0] In,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] OutA,
  output logic             OutAValid,
  input  logic             OutAReady,
  output logic [WIDTH-1:0] OutB,
  output logic             OutBValid,
  input  logic             OutBReady
`ifdef DEMUX_CNT_EN
  ,
  output logic [7:0]       CountA,
  output logic [7:0]       CountB
`endif
);
  logic acc, fill_a, fill_b, drain_a, drain_b;
  // A channel can take a word when it is empty or is being drained this same edge.
  always_comb begin
    InReady = !Reset && (Sel ? (!OutBValid || OutBReady) : (!OutAValid || OutAReady));
    acc     = InValid && InReady;
    fill_a  = acc && !Sel;
    fill_b  = acc && Sel;
    drain_a = OutAValid && OutAReady;
    drain_b = OutBValid && OutBReady;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      OutA      <= '0;
      OutAValid <= 1'b0;
      OutB      <= '0;
      OutBValid <= 1'b0;
    end else begin
      if (fill_a) OutA <= In;
      if (fill_b) OutB <= In;
      OutAValid <= fill_a || (OutAValid && !drain_a);
      OutBValid <= fill_b || (OutBValid && !drain_b);
    end
  end
`ifdef DEMUX_CNT_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      CountA <= '0;
      CountB <= '0;
    end else begin
      if (drain_a) CountA <= CountA + 8'd1;
      if (drain_b) CountB <= CountB + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_demux_1_2_5bit_reg.sv
// tb_demux_1_2_5bit_reg: randomized and directed bench against a queue-based channel model
module tb_demux_1_2_5bit_reg;
  localparam int W = 5;
  logic         Clk = 0, Reset = 1, Sel = 0, InValid = 0, OutAReady = 0, OutBReady = 0;
  logic [W-1:0] In = '0;
  logic         InReady, OutAValid, OutBValid;
  logic [W-1:0] OutA, OutB;
`ifdef DEMUX_CNT_EN
  logic [7:0]   CountA, CountB;
`endif
  int nchk = 0, nerr = 0;
  int qa[$], qb[$];
  int la = 0, lb = 0, ca = 0, cb = 0;
  demux_1_2_5bit_reg #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Sel(Sel), .In(In), .InValid(InValid), .InReady(InReady),
    .OutA(OutA), .OutAValid(OutAValid), .OutAReady(OutAReady),
    .OutB(OutB), .OutBValid(OutBValid), .OutBReady(OutBReady)
`ifdef DEMUX_CNT_EN
    , .CountA(CountA), .CountB(CountB)
`endif
  );
  always #5 Clk = ~Clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic step(input logic r, input logic s, input int d, input logic v,
                      input logic ra, input logic rb);
    logic rdy, da, db, acc;
    @(negedge Clk);
    Reset = r; Sel = s; In = W'(d); InValid = v; OutAReady = ra; OutBReady = rb;
    #1;
    rdy = !r && (s ? (qb.size() == 0 || rb) : (qa.size() == 0 || ra));
    if (v || r) check("inready", InReady, rdy);
    da  = qa.size() > 0 && ra;
    db  = qb.size() > 0 && rb;
    acc = v && rdy;
    @(posedge Clk);
    if (r) begin
      qa.delete(); qb.delete();
      la = 0; lb = 0; ca = 0; cb = 0;
    end else begin
      if (da) begin la = qa.pop_front(); ca = (ca + 1) % 256; end
      if (db) begin lb = qb.pop_front(); cb = (cb + 1) % 256; end
      if (acc) begin
        if (s) qb.push_back(d); else qa.push_back(d);
      end
    end
    #1;
    check("outavalid", OutAValid, qa.size() != 0);
    check("outbvalid", OutBValid, qb.size() != 0);
    check("outa", OutA, qa.size() != 0 ? qa[0] : la);
    check("outb", OutB, qb.size() != 0 ? qb[0] : lb);
`ifdef DEMUX_CNT_EN
    check("counta", CountA, ca);
    check("countb", CountB, cb);
`endif
  endtask
  initial begin
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1, 1);
    check("rst_outa", OutA, 0);
    check("rst_valid", {OutAValid, OutBValid}, 0);
    step(0, 0, 2, 1, 1, 0);
    check("a2_data", OutA, 2);
    check("a2_valids", {OutAValid, OutBValid}, 2'b10);
    step(0, 0, 0, 0, 1, 0);
    check("a2_drained", {OutAValid, OutA}, 2);
    step(0, 1, 3, 1, 0, 0);
    check("b3_held", OutB, 3);
    step(0, 1, 4, 1, 0, 0);
    check("b_stall_rdy", InReady, 0);
    step(0, 0, 9, 0, 0, 0);
    step(0, 1, 4, 1, 0, 0);
    check("b_stall_hold", OutB, 3);
    step(0, 1, 4, 1, 0, 1);
    check("b_swap", {OutBValid, OutB}, {1'b1, 5'd4});
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 7, 1, 0, 1);
    step(0, 1, 31, 1, 0, 0);
    check("b31_data", OutB, 31);
    check("b31_a_kept", {OutAValid, OutA}, {1'b1, 5'd7});
    step(1, 0, 9, 1, 0, 0);
    check("rst_mid", {OutAValid, OutBValid, OutA, OutB}, 0);
    step(0, 1, 5, 1, 0, 0);
    check("post_rst", {OutBValid, OutB}, {1'b1, 5'd5});
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 40) == 0, 1'($urandom), $urandom_range(0, 31),
           $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 2) != 0);
`ifdef DEMUX_CNT_EN
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 257; i++) step(0, 0, i % 32, 1, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    check("cnt_wrap", {CountA, CountB}, {8'd1, 8'd0});
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end
endmodule
